// File: rtl/mv_job_scheduler.sv
// Job sequencer for the matrix-vector Controller: queues {width, mbase, vbase}
// jobs and launches them one at a time with a drain gap and a run watchdog.
module mv_job_scheduler #(
    parameter int QDEPTH       = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 4096,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [8:0]                cmd_width,
    input  logic [11:0]               cmd_mbase,
    input  logic [9:0]                cmd_vbase,
    input  logic                      flush,
    input  logic                      err_clr,
    output logic                      running,
    output logic [8:0]                width,
    output logic [11:0]               mbase,
    output logic [9:0]                vbase,
    input  logic                      finish,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [CNT_W-1:0]          jobs_done,
    output logic                      err_timeout,
    output logic                      err_zero,
    output logic                      done_irq
);

    localparam int PW = $clog2(QDEPTH);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    localparam logic [PW:0]   Q_FULL = (PW + 1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic [8:0]    q_w [QDEPTH];
    logic [11:0]   q_mb [QDEPTH];
    logic [9:0]    q_vb [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] dcnt;
    logic [WW-1:0] wd;

    logic q_empty, head_zero, d_last, to_hit;
    logic push, pop, retire, irq_set, tmo_set, zero_set;

    assign q_empty   = (q_count == '0);
    assign head_zero = (q_w[rd_ptr] == 9'd0);
    assign d_last    = (dcnt == D_LAST);
    assign to_hit    = (TIMEOUT != 0) && (wd == W_LAST);
    assign cmd_ready = (q_count < Q_FULL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!q_empty) state_nx = head_zero ? DRAIN : RUN;
            RUN:     if (finish || to_hit) state_nx = DRAIN;
            DRAIN: begin
                if (d_last) begin
                    if (q_empty)        state_nx = IDLE;
                    else if (head_zero) state_nx = DRAIN;
                    else                state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        running  = (state == RUN);
        busy     = (state != IDLE) || !q_empty;
        push     = cmd_valid && cmd_ready && !flush;
        pop      = !q_empty && ((state == IDLE) || ((state == DRAIN) && d_last));
        zero_set = pop && head_zero;
        tmo_set  = (state == RUN) && to_hit && !finish;
        retire   = ((state == RUN) && (finish || to_hit)) || zero_set;
        irq_set  = (state == DRAIN) && d_last && q_empty;
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_w[wr_ptr]  <= cmd_width;
            q_mb[wr_ptr] <= cmd_mbase;
            q_vb[wr_ptr] <= cmd_vbase;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            q_count <= q_count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width <= '0;
            mbase <= '0;
            vbase <= '0;
        end else if (pop) begin
            width <= q_w[rd_ptr];
            mbase <= q_mb[rd_ptr];
            vbase <= q_vb[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
            wd   <= '0;
        end else begin
            dcnt <= ((state == DRAIN) && !d_last) ? dcnt + 1'b1 : '0;
            wd   <= ((state == RUN) && (state_nx == RUN)) ? wd + 1'b1 : '0;
        end
    end

    // Sticky flags: a set on the same edge as err_clr wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jobs_done   <= '0;
            err_timeout <= 1'b0;
            err_zero    <= 1'b0;
            done_irq    <= 1'b0;
        end else begin
            if (retire) jobs_done <= jobs_done + 1'b1;
            err_timeout <= tmo_set || (err_timeout && !err_clr);
            err_zero    <= zero_set || (err_zero && !err_clr);
            done_irq    <= irq_set;
        end
    end

endmodule

// File: tb/tb_mv_job_scheduler.sv
// Self-checking bench for mv_job_scheduler: table-driven cycle vectors
// plus directed sequences for backpressure, timeout, flush and reset.
module tb_mv_job_scheduler;

    localparam int TO = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [8:0]    cmd_width = '0;
    logic [11:0]   cmd_mbase = '0;
    logic [9:0]    cmd_vbase = '0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          running;
    logic [8:0]    width;
    logic [11:0]   mbase;
    logic [9:0]    vbase;
    logic          finish = 1'b0;
    logic          busy;
    logic [2:0]    q_count;
    logic [CW-1:0] jobs_done;
    logic          err_timeout;
    logic          err_zero;
    logic          done_irq;

    mv_job_scheduler #(
        .QDEPTH(4), .DRAIN_CYCLES(2), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_width(cmd_width), .cmd_mbase(cmd_mbase), .cmd_vbase(cmd_vbase),
        .flush(flush), .err_clr(err_clr),
        .running(running), .width(width), .mbase(mbase), .vbase(vbase),
        .finish(finish), .busy(busy), .q_count(q_count),
        .jobs_done(jobs_done), .err_timeout(err_timeout),
        .err_zero(err_zero), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int irq_cnt = 0;
    int run_cyc = 0;

    always @(negedge clk) begin
        if (done_irq) irq_cnt++;
        if (running) run_cyc++;
    end

    typedef struct {
        bit   rst;
        bit   cv;
        int   w;
        int   mb;
        int   vb;
        bit   fin;
        bit   clr;
        int   rep;
        bit   e_run;
        int   e_q;
        int   e_jobs;
        bit   e_irq;
        bit   e_busy;
        int   e_w;
        bit   e_ez;
        int   e_mb;
        int   e_vb;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    function automatic vec_t v(
        input bit rst, input bit cv, input int w, input int mb, input int vb,
        input bit fin, input bit clr, input int rep,
        input bit run, input int q, input int jobs, input bit irq,
        input bit bsy, input int ew, input bit ez, input int emb, input int evb
    );
        vec_t r;
        r.rst = rst; r.cv = cv; r.w = w; r.mb = mb; r.vb = vb;
        r.fin = fin; r.clr = clr; r.rep = rep;
        r.e_run = run; r.e_q = q; r.e_jobs = jobs; r.e_irq = irq;
        r.e_busy = bsy; r.e_w = ew; r.e_ez = ez; r.e_mb = emb; r.e_vb = evb;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        cmd_valid = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        finish = 1'b0;
        rstn = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
    endtask

    task automatic push(input int w, input int mb, input int vb);
        bit ok;
        ok = 1'b0;
        cmd_width = 9'(w);
        cmd_mbase = 12'(mb);
        cmd_vbase = 10'(vb);
        cmd_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            ok = cmd_ready;
            tick;
        end
        cmd_valid = 1'b0;
        chk("push_accept", 32'(ok), 1);
    endtask

    task automatic run_job(input string nm, input int exp_w, input int hold);
        for (int n = 0; n < 20 && !running; n++) tick;
        chk({nm, "_launch"}, 32'(running), 1);
        chk({nm, "_width"}, 32'(width), exp_w);
        repeat (hold) tick;
        finish = 1'b1;
        tick;
        finish = 1'b0;
        chk({nm, "_stop"}, 32'(running), 0);
    endtask

    int i0, r0, cnt;

    initial begin
        // Test 1: single job, then test 3: zero-width job between two jobs
        tbl.push_back(v(1,0,0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,13,'h100,'h20,0,0,1, 0,1,0,0,1, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    1,0,0,0,1, 13,0,'h100,'h20));
        tbl.push_back(v(0,0,0,0,0,0,0,19,   1,0,0,0,1, 13,0,'h100,'h20));
        tbl.push_back(v(0,0,0,0,0,1,0,1,    0,0,1,0,1, 13,0,'h100,'h20));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,0,1,0,1, 13,0,'h100,'h20));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,0,1,1,0, 13,0,'h100,'h20));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,0,1,0,0, 13,0,'h100,'h20));
        tbl.push_back(v(1,0,0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,5,'h010,'h001,0,0,1, 0,1,0,0,1, 0,0,0,0));
        tbl.push_back(v(0,1,0,'h020,'h002,0,0,1, 1,1,0,0,1, 5,0,'h010,'h001));
        tbl.push_back(v(0,1,5,'h030,'h003,0,0,1, 1,2,0,0,1, 5,0,'h010,'h001));
        tbl.push_back(v(0,0,0,0,0,1,0,1,    0,2,1,0,1, 5,0,'h010,'h001));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,2,1,0,1, 5,0,'h010,'h001));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,1,2,0,1, 0,1,'h020,'h002));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,1,2,0,1, 0,1,'h020,'h002));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    1,0,2,0,1, 5,1,'h030,'h003));
        tbl.push_back(v(0,0,0,0,0,1,0,1,    0,0,3,0,1, 5,1,'h030,'h003));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,0,3,0,1, 5,1,'h030,'h003));
        tbl.push_back(v(0,0,0,0,0,0,0,1,    0,0,3,1,0, 5,1,'h030,'h003));
        tbl.push_back(v(0,0,0,0,0,0,1,1,    0,0,3,0,0, 5,0,'h030,'h003));

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            if (t.rst) begin
                do_reset;
                chk($sformatf("row%0d_ready", i), 32'(cmd_ready), 1);
                chk($sformatf("row%0d_etmo", i), 32'(err_timeout), 0);
            end else begin
                cmd_valid = t.cv;
                cmd_width = 9'(t.w);
                cmd_mbase = 12'(t.mb);
                cmd_vbase = 10'(t.vb);
                finish = t.fin;
                err_clr = t.clr;
                repeat (t.rep) tick;
                cmd_valid = 1'b0;
                finish = 1'b0;
                err_clr = 1'b0;
            end
            chk($sformatf("row%0d_running", i), 32'(running), 32'(t.e_run));
            chk($sformatf("row%0d_qcount", i), 32'(q_count), t.e_q);
            chk($sformatf("row%0d_jobs", i), 32'(jobs_done), t.e_jobs);
            chk($sformatf("row%0d_irq", i), 32'(done_irq), 32'(t.e_irq));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(t.e_busy));
            chk($sformatf("row%0d_width", i), 32'(width), t.e_w);
            chk($sformatf("row%0d_ezero", i), 32'(err_zero), 32'(t.e_ez));
            chk($sformatf("row%0d_mbase", i), 32'(mbase), t.e_mb);
            chk($sformatf("row%0d_vbase", i), 32'(vbase), t.e_vb);
        end

        // Test 2: five jobs back-to-back, backpressure at q_count=4
        do_reset;
        for (int i = 0; i < 5; i++) push(i + 1, 16 * i, i);
        chk("bp_qcount", 32'(q_count), 4);
        chk("bp_ready", 32'(cmd_ready), 0);
        chk("bp_running", 32'(running), 1);
        i0 = irq_cnt;
        for (int i = 0; i < 5; i++) begin
            run_job($sformatf("bp_job%0d", i), i + 1, 3);
            if (i == 0) chk("bp_q_after_first", 32'(q_count), 4);
        end
        repeat (3) tick;
        chk("bp_irq_once", 32'(irq_cnt - i0), 1);
        chk("bp_jobs", 32'(jobs_done), 5);
        chk("bp_idle", 32'(busy), 0);

        // Test 4: watchdog abort, next job launches after drain
        do_reset;
        push(7, 'h111, 'h11);
        push(9, 'h222, 'h22);
        cnt = 0;
        while (running && cnt < 100) begin
            cnt++;
            tick;
        end
        chk("to_run_len", 32'(cnt), TO);
        chk("to_err", 32'(err_timeout), 1);
        chk("to_jobs", 32'(jobs_done), 1);
        chk("to_width_hold", 32'(width), 7);
        tick;
        chk("to_drain2", 32'(running), 0);
        tick;
        chk("to_next_run", 32'(running), 1);
        chk("to_next_width", 32'(width), 9);
        repeat (2) tick;
        finish = 1'b1;
        tick;
        finish = 1'b0;
        chk("to_jobs2", 32'(jobs_done), 2);
        chk("to_err_sticky", 32'(err_timeout), 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("to_err_clr", 32'(err_timeout), 0);
        repeat (3) tick;
        push(4, 'h333, 'h33);
        tick;
        chk("edge_launch", 32'(running), 1);
        repeat (TO - 1) tick;
        chk("edge_pre", 32'(running), 1);
        finish = 1'b1;
        tick;
        finish = 1'b0;
        chk("edge_stop", 32'(running), 0);
        chk("edge_no_err", 32'(err_timeout), 0);
        chk("edge_jobs", 32'(jobs_done), 3);

        // Test 5: flush with three queued while a job runs
        do_reset;
        for (int i = 0; i < 4; i++) push(3 + i, i, i);
        chk("fl_q_before", 32'(q_count), 3);
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_width = 9'd9;
        tick;
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("fl_q_after", 32'(q_count), 0);
        chk("fl_running", 32'(running), 1);
        chk("fl_width", 32'(width), 3);
        i0 = irq_cnt;
        repeat (2) tick;
        finish = 1'b1;
        tick;
        finish = 1'b0;
        chk("fl_jobs", 32'(jobs_done), 1);
        repeat (3) tick;
        chk("fl_irq", 32'(irq_cnt - i0), 1);
        chk("fl_idle", 32'(busy), 0);
        chk("fl_no_launch", 32'(running), 0);

        // Test 6: asynchronous reset mid-run
        do_reset;
        push(11, 'h0ab, 'h0c);
        push(12, 'h0cd, 'h0d);
        tick;
        chk("ar_pre_run", 32'(running), 1);
        chk("ar_pre_q", 32'(q_count), 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_running", 32'(running), 0);
        chk("ar_width", 32'(width), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_qcount", 32'(q_count), 0);
        #2 rstn = 1'b1;
        tick;
        push(6, 'h001, 'h001);
        chk("ar_post_q", 32'(q_count), 1);
        tick;
        chk("ar_post_run", 32'(running), 1);
        chk("ar_post_width", 32'(width), 6);

        // Nine zero-width jobs: jobs_done wraps, running never rises
        do_reset;
        r0 = run_cyc;
        for (int i = 0; i < 9; i++) push(0, i, i);
        i0 = irq_cnt;
        for (int n = 0; n < 100 && irq_cnt == i0; n++) tick;
        chk("wr_irq", 32'(irq_cnt - i0), 1);
        chk("wr_jobs", 32'(jobs_done), 9 % (1 << CW));
        chk("wr_ezero", 32'(err_zero), 1);
        chk("wr_no_run", 32'(run_cyc - r0), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
